// File: rtl/strassen_result_serializer_if.sv
// strassen_result_serializer_if: parallel matrix input and per-element output handshake bundle
interface strassen_result_serializer_if #(
   parameter int W  = 8,
   parameter int OW = 16
);
   localparam int IW = 2*W+2;
   logic                 in_valid;
   logic                 in_ready;
   logic [3:0][IW-1:0]   in_cr;
   logic [3:0][IW-1:0]   in_ci;
   logic                 out_valid;
   logic                 out_ready;
   logic signed [OW-1:0] out_re;
   logic signed [OW-1:0] out_im;
   logic [1:0]           out_idx;
   logic                 out_last;
   modport master (
      output in_valid, in_cr, in_ci, out_ready,
      input  in_ready, out_valid, out_re, out_im, out_idx, out_last
   );
   modport slave (
      input  in_valid, in_cr, in_ci, out_ready,
      output in_ready, out_valid, out_re, out_im, out_idx, out_last
   );
endinterface

// File: rtl/strassen_result_serializer.sv
// strassen_result_serializer: streams a 2x2 complex result matrix one narrowed element per beat
module strassen_result_serializer #(
   parameter int W   = 8,
   parameter int OW  = 16,
   parameter bit SAT = 1'b1
) (
   input  logic                          clk,
   input  logic                          rst,
   strassen_result_serializer_if.slave   bus,
   output logic                          ovf,
   input  logic                          ovf_clr
);
   localparam int IW = 2*W+2;
   localparam logic signed [IW-1:0] MAXV = {{(IW-OW+1){1'b0}}, {(OW-1){1'b1}}};
   localparam logic signed [IW-1:0] MINV = {{(IW-OW+1){1'b1}}, {(OW-1){1'b0}}};
   localparam logic [OW-1:0] MAXO = {1'b0, {(OW-1){1'b1}}};
   localparam logic [OW-1:0] MINO = {1'b1, {(OW-1){1'b0}}};

   typedef enum logic [1:0] {EMPTY, ACTIVE, FULL} state_t;

   state_t               state;
   logic [3:0][IW-1:0]   act_cr, act_ci, pend_cr, pend_ci;
   logic [1:0]           idx;
   logic                 act_valid, acc, beat, fin;
   logic signed [IW-1:0] cur_re, cur_im;

   function automatic logic out_of_range(input logic signed [IW-1:0] v);
      return v > MAXV || v < MINV;
   endfunction

   // With OW == IW the limits span the full input range, so nothing is ever out of range
   function automatic logic [OW-1:0] narrow(input logic signed [IW-1:0] v);
      return (SAT && out_of_range(v)) ? (v[IW-1] ? MINO : MAXO) : v[OW-1:0];
   endfunction

   assign act_valid     = state != EMPTY;
   assign bus.in_ready  = state != FULL;
   assign acc           = bus.in_valid && bus.in_ready;
   assign beat          = act_valid && bus.out_ready;
   assign fin           = beat && idx == 2'd3;
   assign cur_re        = act_cr[idx];
   assign cur_im        = act_ci[idx];
   assign bus.out_valid = act_valid;
   assign bus.out_re    = act_valid ? narrow(cur_re) : '0;
   assign bus.out_im    = act_valid ? narrow(cur_im) : '0;
   assign bus.out_idx   = act_valid ? idx : 2'd0;
   assign bus.out_last  = act_valid && idx == 2'd3;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= EMPTY;
         idx   <= '0;
         ovf   <= 1'b0;
      end else begin
         ovf <= (beat && (out_of_range(cur_re) || out_of_range(cur_im))) || (ovf && !ovf_clr);
         if (beat)
            idx <= idx + 2'd1;
         case (state)
            EMPTY: if (acc) begin
               act_cr <= bus.in_cr;
               act_ci <= bus.in_ci;
               state  <= ACTIVE;
            end
            ACTIVE: if (fin && !acc) begin
               state <= EMPTY;
            end else if (fin) begin
               act_cr <= bus.in_cr;
               act_ci <= bus.in_ci;
            end else if (acc) begin
               pend_cr <= bus.in_cr;
               pend_ci <= bus.in_ci;
               state   <= FULL;
            end
            // Pending promotes on the last beat so the next matrix starts without a bubble
            FULL: if (fin) begin
               act_cr <= pend_cr;
               act_ci <= pend_ci;
               state  <= ACTIVE;
            end
            default: state <= EMPTY;
         endcase
      end
   end
endmodule

// File: tb/tb_strassen_result_serializer.sv
// tb_strassen_result_serializer: directed checks of ordering, narrowing, buffering, backpressure and reset
module tb_strassen_result_serializer;
   localparam int W  = 8;
   localparam int OW = 16;
   localparam int IW = 2*W+2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic ovf_clr = 1'b0;
   logic ovf_a, ovf_b;
   int   n_chk = 0;
   int   n_pass = 0;
   int   mi;
   logic took;

   int mcr[8][4] = '{'{1, -2, 3, -4}, '{1, 40000, 3, 4}, '{10, -20, 30, -40}, '{100, 200, -300, 400},
                     '{32767, -32768, 7, 0}, '{50, 51, 52, 53}, '{60, 61, 62, 63}, '{999, 998, 997, 996}};
   int mci[8][4] = '{'{5, 6, -7, 8}, '{5, 6, -50000, 8}, '{11, 12, 13, 14}, '{-1, -2, -3, -4},
                     '{0, -9, 9, 1000}, '{-50, -51, -52, -53}, '{70, 71, 72, 73}, '{1, 2, 3, 4}};

   always #5 clk = ~clk;

   strassen_result_serializer_if #(.W(W), .OW(OW)) a ();
   strassen_result_serializer_if #(.W(W), .OW(OW)) b ();

   assign b.in_valid  = a.in_valid;
   assign b.in_cr     = a.in_cr;
   assign b.in_ci     = a.in_ci;
   assign b.out_ready = a.out_ready;

   strassen_result_serializer #(.W(W), .OW(OW), .SAT(1'b1)) dut_sat (
      .clk(clk), .rst(rst), .bus(a.slave), .ovf(ovf_a), .ovf_clr(ovf_clr)
   );
   strassen_result_serializer #(.W(W), .OW(OW), .SAT(1'b0)) dut_wrap (
      .clk(clk), .rst(rst), .bus(b.slave), .ovf(ovf_b), .ovf_clr(ovf_clr)
   );

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp)
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      else
         n_pass++;
   endtask

   task automatic set_in(input int m);
      for (int k = 0; k < 4; k++) begin
         a.in_cr[k] = IW'(mcr[m][k]);
         a.in_ci[k] = IW'(mci[m][k]);
      end
   endtask

   task automatic send(input int m);
      set_in(m);
      a.in_valid = 1'b1;
      @(negedge clk);
      a.in_valid = 1'b0;
   endtask

   task automatic beat_chk(input string tag, input int m, input int k);
      chk({tag, "_valid"}, int'(a.out_valid), 1);
      chk({tag, "_idx"}, int'(a.out_idx), k);
      chk({tag, "_re"}, $signed(a.out_re), mcr[m][k]);
      chk({tag, "_im"}, $signed(a.out_im), mci[m][k]);
      chk({tag, "_last"}, int'(a.out_last), int'(k == 3));
   endtask

   initial begin
      a.in_valid  = 1'b0;
      a.out_ready = 1'b1;
      a.in_cr     = '0;
      a.in_ci     = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_valid", int'(a.out_valid), 0);
      chk("rst_ready", int'(a.in_ready), 1);
      chk("rst_re", $signed(a.out_re), 0);
      chk("rst_im", $signed(a.out_im), 0);
      chk("rst_idx", int'(a.out_idx), 0);
      chk("rst_last", int'(a.out_last), 0);
      chk("rst_ovf", int'(ovf_a), 0);

      send(0);
      for (int k = 0; k < 4; k++) begin
         beat_chk("single", 0, k);
         @(negedge clk);
      end
      chk("single_done", int'(a.out_valid), 0);
      chk("single_ovf", int'(ovf_a), 0);

      send(1);
      chk("sat_b0_re", $signed(a.out_re), 1);
      @(negedge clk);
      chk("sat_hi", $signed(a.out_re), 32767);
      chk("wrap_hi", $signed(b.out_re), -25536);
      chk("ovf_pre", int'(ovf_a), 0);
      @(negedge clk);
      chk("ovf_sat", int'(ovf_a), 1);
      chk("ovf_wrap", int'(ovf_b), 1);
      chk("sat_lo", $signed(a.out_im), -32768);
      chk("wrap_lo", $signed(b.out_im), 15536);
      repeat (2) @(negedge clk);
      chk("sat_done", int'(a.out_valid), 0);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      chk("clr_sat", int'(ovf_a), 0);
      chk("clr_wrap", int'(ovf_b), 0);

      set_in(2);
      a.in_valid = 1'b1;
      mi = 2;
      for (int c = 0; c < 12; c++) begin
         took = a.in_valid && a.in_ready;
         @(negedge clk);
         if (took) begin
            mi++;
            if (mi > 4) a.in_valid = 1'b0;
            else set_in(mi);
         end
         beat_chk("b2b", 2 + c/4, c % 4);
         chk("b2b_ready", int'(a.in_ready), int'(c % 4 == 0 || c >= 8));
      end
      @(negedge clk);
      chk("b2b_done", int'(a.out_valid), 0);

      send(5);
      set_in(6);
      a.in_valid = 1'b1;
      @(negedge clk);
      a.in_valid = 1'b0;
      @(negedge clk);
      a.out_ready = 1'b0;
      set_in(7);
      a.in_valid = 1'b1;
      for (int s = 0; s < 5; s++) begin
         @(negedge clk);
         beat_chk("bp_hold", 5, 2);
         chk("bp_refuse", int'(a.in_ready), 0);
      end
      a.out_ready = 1'b1;
      a.in_valid  = 1'b0;
      for (int k = 0; k < 6; k++) begin
         beat_chk("bp_resume", k < 2 ? 5 : 6, k < 2 ? k + 2 : k - 2);
         @(negedge clk);
      end
      chk("bp_done", int'(a.out_valid), 0);

      send(1);
      @(negedge clk);
      chk("coll_pre", int'(ovf_a), 0);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      chk("coll_set_wins", int'(ovf_a), 1);
      repeat (2) @(negedge clk);

      send(0);
      set_in(2);
      a.in_valid = 1'b1;
      @(negedge clk);
      a.in_valid = 1'b0;
      chk("mid_idx", int'(a.out_idx), 1);
      chk("mid_full", int'(a.in_ready), 0);
      chk("mid_ovf", int'(ovf_a), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mrst_valid", int'(a.out_valid), 0);
      chk("mrst_ready", int'(a.in_ready), 1);
      chk("mrst_ovf", int'(ovf_a), 0);
      @(negedge clk);
      chk("mrst_quiet", int'(a.out_valid), 0);
      send(3);
      beat_chk("post_rst", 3, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
